// File: rtl/afe_spi_mode.sv
// afe_spi_mode: SPI master with configurable length, mode, bit order, device select and CS hold
module afe_spi_mode #(
  parameter int CLK_RATE  = 100000000,
  parameter int BIT_RATE  = 12500000,
  parameter int CSB_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 cfgStrobe,
  input  logic                 dataStrobe,
  input  logic [31:0]          gpioOut,
  output logic [31:0]          status,
  output logic [31:0]          rdData,
  output logic                 SPI_CLK,
  output logic [CSB_WIDTH-1:0] SPI_CSB,
  output logic                 SPI_SDI,
  input  logic                 SPI_SDO
);
  localparam int DIV_RAW = (CLK_RATE + 2 * BIT_RATE - 1) / (2 * BIT_RATE);
  localparam int DIV = DIV_RAW < 1 ? 1 : DIV_RAW;
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, LAG} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0] hp_q, hp_d;
  logic [15:0] cfg_q, cfg_d;
  logic [31:0] tx_q, tx_d, rx_q, rx_d, rd_q, rd_d;
  logic [CSB_WIDTH-1:0] csb_q, csb_d;
  logic sclk_q, sclk_d, sdi_q, sdi_d, ovr_q, ovr_d, sel_err_q, sel_err_d;
  logic tick, busy, lead_ev, trail_ev, shift_ev, samp_ev, sel_ok;
  logic [4:0] len, len_w;
  logic [6:0] nbits;
  logic [31:0] rev, ld, rx_shift, rd_asm;
  // Decode config, edge events, transmit load word and received-word assembly
  always_comb begin
    tick = cnt_q == CW'(DIV - 1);
    busy = state_q != IDLE;
    len = cfg_q[4:0];
    nbits = {2'b0, len} + 7'd1;
    len_w = gpioOut[4:0] < 5'd7 ? 5'd7 : gpioOut[4:0];
    sel_ok = int'({28'b0, cfg_q[11:8]}) < CSB_WIDTH;
    lead_ev = state_q == SHIFT && tick && !hp_q[0];
    trail_ev = state_q == SHIFT && tick && hp_q[0];
    shift_ev = cfg_q[6] ? lead_ev : trail_ev;
    samp_ev = cfg_q[6] ? trail_ev : lead_ev;
    rev = {<<{gpioOut}};
    ld = cfg_q[7] ? rev : gpioOut << (7'd32 - nbits);
    rx_shift = samp_ev ? {rx_q[30:0], SPI_SDO} : rx_q;
    rd_asm = '0;
    for (int i = 0; i < 32; i++)
      if (5'(i) <= len) rd_asm[i] = cfg_q[7] ? rx_shift[len - 5'(i)] : rx_shift[i];
  end
  // Frame state machine: tick divider, SCLK/CSB/SDI generation, CSR updates
  always_comb begin
    state_d = state_q;
    cnt_d = (state_q == IDLE || tick) ? '0 : cnt_q + CW'(1);
    hp_d = hp_q;
    cfg_d = cfg_q;
    tx_d = tx_q;
    rx_d = rx_shift;
    rd_d = rd_q;
    csb_d = csb_q;
    sclk_d = sclk_q;
    sdi_d = sdi_q;
    ovr_d = ovr_q;
    sel_err_d = sel_err_q;
    case (state_q)
      IDLE: begin
        sclk_d = cfg_q[5];
        sdi_d = 1'b0;
        csb_d = '1;
        if (cfgStrobe) begin
          cfg_d = {gpioOut[15:5], len_w};
          ovr_d = 1'b0;
          sel_err_d = 1'b0;
        end
        if (dataStrobe && sel_ok) begin
          state_d = LEAD;
          hp_d = '0;
          tx_d = cfg_q[6] ? ld : ld << 1;
          sdi_d = cfg_q[6] ? 1'b0 : ld[31];
          rx_d = '0;
          csb_d = ~(CSB_WIDTH'(1) << cfg_q[11:8]);
        end else if (dataStrobe) sel_err_d = 1'b1;
      end
      LEAD: if (tick) state_d = SHIFT;
      SHIFT: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          hp_d = hp_q + 7'd1;
          if (hp_q == (nbits << 1) - 7'd1) begin
            state_d = LAG;
            hp_d = '0;
            rd_d = rd_asm;
          end
        end
        if (shift_ev) begin
          sdi_d = tx_q[31];
          tx_d = tx_q << 1;
        end
      end
      default: if (tick) begin
        hp_d = hp_q + 7'd1;
        if (hp_q == {3'b0, cfg_q[15:12]}) begin
          state_d = IDLE;
          hp_d = '0;
          csb_d = '1;
          sdi_d = 1'b0;
          sclk_d = cfg_q[5];
        end
      end
    endcase
    if (busy && dataStrobe) ovr_d = 1'b1;
  end
  // State registers; reset aborts any frame and restores idle bus levels
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hp_q <= '0;
      cfg_q <= 16'h001F;
      tx_q <= '0;
      rx_q <= '0;
      rd_q <= '0;
      csb_q <= '1;
      sclk_q <= 1'b0;
      sdi_q <= 1'b0;
      ovr_q <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hp_q <= hp_d;
      cfg_q <= cfg_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      rd_q <= rd_d;
      csb_q <= csb_d;
      sclk_q <= sclk_d;
      sdi_q <= sdi_d;
      ovr_q <= ovr_d;
      sel_err_q <= sel_err_d;
    end
  end
  assign status = {busy, ovr_q, sel_err_q, 13'b0, cfg_q};
  assign rdData = rd_q;
  assign SPI_CLK = sclk_q;
  assign SPI_CSB = csb_q;
  assign SPI_SDI = sdi_q;
endmodule
